// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU result stage: result-select encoding,
// default widths and the buffered entry record.
package alu_pkg;

    localparam int DW_DEF = 32;
    localparam int AW_DEF = 32;
    localparam int RW_DEF = 5;

    localparam logic [1:0] RES_SUM = 2'd0;
    localparam logic [1:0] RES_SLT = 2'd1;
    localparam logic [1:0] RES_BEQ = 2'd2;
    localparam logic [1:0] RES_BNE = 2'd3;

    // One result fully resolved at input accept; fault entries carry we=0.
    typedef struct packed {
        logic [DW_DEF-1:0] result;
        logic              we;
        logic [RW_DEF-1:0] rd;
        logic [AW_DEF-1:0] pc;
        logic              br_taken;
        logic              fault;
    } alu_entry_t;

endpackage

// File: rtl/skid_buffer2.sv
// Two-entry valid/ready buffer (main + skid) of alu_entry_t. in_ready depends
// only on the registered skid occupancy; flush empties both entries.
module skid_buffer2
    import alu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  alu_entry_t in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output alu_entry_t out_data
);

    alu_entry_t main_q;
    alu_entry_t skid_q;
    logic       main_vld;
    logic       skid_vld;
    logic       push;
    logic       pop;

    assign in_ready  = ~skid_vld;
    assign out_valid = main_vld;
    assign out_data  = main_q;
    assign push      = in_valid & ~skid_vld;
    assign pop       = main_vld & out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else if (flush) begin
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (!main_vld) begin
                        main_q   <= in_data;
                        main_vld <= 1'b1;
                    end else begin
                        skid_q   <= in_data;
                        skid_vld <= 1'b1;
                    end
                end
                2'b01: begin
                    main_q   <= skid_q;
                    main_vld <= skid_vld;
                    skid_vld <= 1'b0;
                end
                2'b11: begin
                    // Occupancy unchanged; the older skid entry moves up first.
                    if (skid_vld) begin
                        main_q <= skid_q;
                        skid_q <= in_data;
                    end else begin
                        main_q <= in_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// EX/MEM result stage: selects SUM/SLT/branch result, converts trapping overflow
// into a precise exception. Optional counters under ALU_RESULT_STAGE_STATS_EN.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_s,
    input  logic          in_z,
    input  logic          in_v,
    input  logic          in_n,
    input  logic [1:0]    in_op,
    input  logic          in_trap,
    input  logic          in_we,
    input  logic [RW-1:0] in_rd,
    input  logic [AW-1:0] in_pc,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_result,
    output logic          out_we,
    output logic [RW-1:0] out_rd,
    output logic          out_br_taken,
    output logic          exc_valid,
    output logic [AW-1:0] exc_epc,
    input  logic          exc_ack
`ifdef ALU_RESULT_STAGE_STATS_EN
    ,
    output logic [15:0]   ovf_count,
    output logic [31:0]   retired_count
`endif
);

    typedef enum logic {IDLE, PENDING} state_t;

    state_t     state;
    alu_entry_t new_entry;
    alu_entry_t head;
    logic       buf_in_valid;
    logic       buf_out_valid;
    logic       buf_out_ready;
    logic       pending;
    logic       out_fire;
    logic       raise;

    assign pending = (state == PENDING);

    always_comb begin
        new_entry          = '0;
        new_entry.rd       = in_rd;
        new_entry.pc       = in_pc;
        new_entry.fault    = in_trap & in_v;
        new_entry.we       = in_we & ~(in_trap & in_v);
        new_entry.result   = in_s;
        new_entry.br_taken = 1'b0;
        case (in_op)
            RES_SLT: new_entry.result   = {{(DW-1){1'b0}}, in_n};
            RES_BEQ: new_entry.br_taken = in_z;
            RES_BNE: new_entry.br_taken = ~in_z;
            default: ;
        endcase
    end

    // While PENDING the buffer is empty, so in_ready stays 1 and beats are squashed.
    assign buf_in_valid  = in_valid & ~pending;
    assign buf_out_ready = out_ready & ~pending;

    skid_buffer2 u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (raise),
        .in_valid  (buf_in_valid),
        .in_ready  (in_ready),
        .in_data   (new_entry),
        .out_valid (buf_out_valid),
        .out_ready (buf_out_ready),
        .out_data  (head)
    );

    assign out_valid    = buf_out_valid & ~pending;
    assign out_result   = head.result;
    assign out_we       = head.we;
    assign out_rd       = head.rd;
    assign out_br_taken = head.br_taken;

    assign out_fire = out_valid & out_ready;
    assign raise    = out_fire & head.fault;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            exc_valid <= 1'b0;
            exc_epc   <= '0;
        end else begin
            exc_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (raise) begin
                        state     <= PENDING;
                        exc_valid <= 1'b1;
                        exc_epc   <= head.pc;
                    end
                end
                PENDING: begin
                    if (exc_ack) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_RESULT_STAGE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_count     <= '0;
            retired_count <= '0;
        end else begin
            if (raise && ovf_count != 16'hFFFF) ovf_count <= ovf_count + 16'd1;
            if (out_fire && !head.fault)        retired_count <= retired_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed + randomized bench for alu_result_stage against a queue-based model
// of a depth-2 FIFO with an IDLE/PENDING exception flag.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_s;
    logic        in_z, in_v, in_n;
    logic [1:0]  in_op;
    logic        in_trap, in_we;
    logic [4:0]  in_rd;
    logic [31:0] in_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_we;
    logic [4:0]  out_rd;
    logic        out_br_taken;
    logic        exc_valid;
    logic [31:0] exc_epc;
    logic        exc_ack;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_s(in_s), .in_z(in_z), .in_v(in_v), .in_n(in_n),
        .in_op(in_op), .in_trap(in_trap), .in_we(in_we), .in_rd(in_rd), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_we(out_we), .out_rd(out_rd),
        .out_br_taken(out_br_taken),
        .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_ack(exc_ack)
    );

    typedef struct {
        logic [31:0] res;
        logic        we;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        br;
        logic        fault;
    } ent_t;

    ent_t        q[$];
    bit          pend;
    bit          m_exc;
    logic [31:0] m_epc;
    bit          last_acc;
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic ent_t mk();
        ent_t e;
        e.rd    = in_rd;
        e.pc    = in_pc;
        e.fault = in_trap && in_v;
        e.we    = e.fault ? 1'b0 : in_we;
        e.res   = (in_op == 2'd1) ? {31'd0, in_n} : in_s;
        e.br    = (in_op == 2'd2) ? in_z : (in_op == 2'd3) ? !in_z : 1'b0;
        return e;
    endfunction

    task automatic compare();
        bit ov;
        ov = !pend && q.size() > 0;
        chk("in_ready", {63'd0, in_ready}, {63'd0, pend || q.size() < 2});
        chk("out_valid", {63'd0, out_valid}, {63'd0, ov});
        chk("exc_valid", {63'd0, exc_valid}, {63'd0, m_exc});
        chk("exc_epc", {32'd0, exc_epc}, {32'd0, m_epc});
        if (ov) begin
            chk("out_result", {32'd0, out_result}, {32'd0, q[0].res});
            chk("out_we", {63'd0, out_we}, {63'd0, q[0].we});
            chk("out_rd", {59'd0, out_rd}, {59'd0, q[0].rd});
            chk("out_br_taken", {63'd0, out_br_taken}, {63'd0, q[0].br});
        end
    endtask

    // One clock: check outputs, advance the model with pre-edge inputs, take the edge.
    task automatic cyc();
        bit   rdy, acc_in, acc_out, raised;
        ent_t h;
        #1;
        compare();
        if (!rst_n) begin
            @(posedge clk); #1;
            q.delete(); pend = 0; m_exc = 0; m_epc = '0; last_acc = 0;
            return;
        end
        rdy     = pend || q.size() < 2;
        acc_in  = in_valid && rdy;
        acc_out = !pend && q.size() > 0 && out_ready;
        raised  = 0;
        last_acc = acc_in;
        if (acc_out) begin
            h = q.pop_front();
            if (h.fault) begin
                raised = 1;
                m_epc  = h.pc;
                q.delete();
            end
        end
        if (acc_in && !pend && !raised) q.push_back(mk());
        if (raised) pend = 1;
        else if (pend && exc_ack) pend = 0;
        m_exc = raised;
        @(posedge clk); #1;
    endtask

    task automatic beat(input logic [31:0] s, input logic [1:0] op, input logic z, input logic n,
                        input logic v, input logic trap, input logic we, input logic [4:0] rd,
                        input logic [31:0] pc);
        in_valid = 1; in_s = s; in_op = op; in_z = z; in_n = n; in_v = v;
        in_trap = trap; in_we = we; in_rd = rd; in_pc = pc;
    endtask

    initial begin
        rst_n = 0; in_valid = 0; out_ready = 0; exc_ack = 0;
        beat(0, 0, 0, 0, 0, 0, 0, 0, 0); in_valid = 0;
        q.delete(); pend = 0; m_exc = 0; m_epc = '0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1;

        // Reset state
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_result", {32'd0, out_result}, 64'd0);
        chk("rst_out_we", {63'd0, out_we}, 64'd0);
        chk("rst_out_rd", {59'd0, out_rd}, 64'd0);
        chk("rst_br", {63'd0, out_br_taken}, 64'd0);
        chk("rst_exc_valid", {63'd0, exc_valid}, 64'd0);
        chk("rst_exc_epc", {32'd0, exc_epc}, 64'd0);

        // SUM, no stall
        out_ready = 1;
        beat(32'h5, 0, 0, 0, 0, 0, 1, 3, 32'h100);
        cyc(); in_valid = 0;
        chk("sum_valid", {63'd0, out_valid}, 64'd1);
        chk("sum_result", {32'd0, out_result}, 64'd5);
        chk("sum_we", {63'd0, out_we}, 64'd1);
        chk("sum_rd", {59'd0, out_rd}, 64'd3);
        cyc();

        // SLT with n=1 then n=0
        beat(32'hFFFF_FFFE, 1, 0, 1, 0, 0, 1, 4, 32'h104);
        cyc();
        chk("slt1_result", {32'd0, out_result}, 64'd1);
        beat(32'hFFFF_FFFE, 1, 0, 0, 0, 0, 1, 4, 32'h108);
        cyc(); in_valid = 0;
        chk("slt0_result", {32'd0, out_result}, 64'd0);
        cyc();

        // Backpressure: three beats into a two-entry stage
        out_ready = 0;
        beat(32'd1, 0, 0, 0, 0, 0, 1, 1, 32'h200); cyc();
        beat(32'd2, 0, 0, 0, 0, 0, 1, 2, 32'h204); cyc();
        beat(32'd3, 0, 0, 0, 0, 0, 1, 3, 32'h208);
        chk("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        cyc();
        chk("bp_head", {32'd0, out_result}, 64'd1);
        out_ready = 1;
        begin
            int n = 0;
            last_acc = 0;
            while (!last_acc && n < 10) begin cyc(); n++; end
            chk("bp_third_accepted", {63'd0, last_acc}, 64'd1);
        end
        in_valid = 0;
        repeat (4) cyc();
        chk("bp_drained", {63'd0, out_valid}, 64'd0);

        // Overflow trap followed by a beat that must be flushed
        beat(32'h8000_0000, 0, 0, 1, 1, 1, 1, 5, 32'h0040_0010); cyc();
        chk("trap_we", {63'd0, out_we}, 64'd0);
        beat(32'h1234, 0, 0, 0, 0, 0, 1, 6, 32'h0040_0014); cyc();
        in_valid = 0;
        chk("trap_exc_pulse", {63'd0, exc_valid}, 64'd1);
        chk("trap_epc", {32'd0, exc_epc}, 64'h0040_0010);
        cyc();
        chk("trap_exc_one_cycle", {63'd0, exc_valid}, 64'd0);
        chk("trap_squashed", {63'd0, out_valid}, 64'd0);
        beat(32'h999, 0, 0, 0, 0, 0, 1, 9, 32'h0040_0018); cyc();
        in_valid = 0;
        chk("pend_squash", {63'd0, out_valid}, 64'd0);
        exc_ack = 1; cyc(); exc_ack = 0;
        beat(32'h77, 0, 0, 0, 0, 0, 1, 7, 32'h0040_0020); cyc();
        in_valid = 0;
        chk("post_ack_result", {32'd0, out_result}, 64'h77);
        chk("post_ack_epc_held", {32'd0, exc_epc}, 64'h0040_0010);
        cyc();

        // Unsigned overflow: no trap
        beat(32'h1, 0, 0, 0, 1, 0, 1, 8, 32'h300); cyc(); in_valid = 0;
        chk("uovf_we", {63'd0, out_we}, 64'd1);
        cyc();
        chk("uovf_no_exc", {63'd0, exc_valid}, 64'd0);

        // Branch taken, then reset with two entries held
        out_ready = 0;
        beat(32'h40, 3, 0, 0, 0, 0, 0, 0, 32'h400); cyc();
        chk("bne_taken", {63'd0, out_br_taken}, 64'd1);
        beat(32'h44, 2, 0, 0, 0, 0, 0, 0, 32'h404); cyc();
        in_valid = 0;
        chk("two_held", {63'd0, in_ready}, 64'd0);
        rst_n = 0; cyc(); rst_n = 1;
        chk("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst2_exc_epc", {32'd0, exc_epc}, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            beat($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)), $urandom);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            exc_ack   = ($urandom_range(0, 3) == 0);
            cyc();
        end
        in_valid = 0; exc_ack = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
